// File: rtl/inst_fetch_responder.sv
// Instruction-memory responder: reads PC and PC+4 from a single-beat memory port and returns a dual-issue bundle.
// Optional one-entry bundle buffer enabled with `define FETCH_BUF_EN.
module inst_fetch_responder #(
  parameter logic [31:0] MEM_LIMIT = 32'h0000_1000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_pc,
  output logic [31:0] rsp_inst0,
  output logic [31:0] rsp_inst1,
  output logic        rsp_adel,
  output logic        rsp_fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RESP, DRAIN} state_t;

  state_t      state, state_next;
  logic        accept, pc_adel, pc_fault, slot1_out;
  logic [31:0] pc_plus4;
  logic        buf_hit;
  logic [31:0] buf_inst0, buf_inst1;

  assign accept    = (state == IDLE) && req_valid && !flush;
  assign pc_adel   = (req_pc[1:0] != 2'b00);
  assign pc_fault  = (req_pc >= MEM_LIMIT);
  assign pc_plus4  = rsp_pc + 32'd4;
  assign slot1_out = (pc_plus4 >= MEM_LIMIT);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_req   = (state == RD0) || (state == RD1) || (state == DRAIN);

`ifdef FETCH_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_tag;
  logic        buf_fill;

  // A miss that reaches RESP from a memory read is always a non-error bundle.
  assign buf_fill = ((state == RD0) || (state == RD1)) && (state_next == RESP);
  assign buf_hit  = buf_valid && (req_pc == buf_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_inst0 <= '0;
      buf_inst1 <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (buf_fill) begin
      buf_valid <= 1'b1;
      buf_tag   <= rsp_pc;
      buf_inst0 <= (state == RD0) ? mem_rdata : rsp_inst0;
      buf_inst1 <= (state == RD0) ? NOP_WORD  : mem_rdata;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_inst0 = NOP_WORD;
  assign buf_inst1 = NOP_WORD;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (pc_adel || pc_fault || buf_hit) state_next = RESP;
          else                                state_next = RD0;
        end
      end
      RD0: begin
        if (mem_ack) begin
          if (flush)          state_next = IDLE;
          else if (slot1_out) state_next = RESP;
          else                state_next = RD1;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      RD1: begin
        if (mem_ack)    state_next = flush ? IDLE : RESP;
        else if (flush) state_next = DRAIN;
      end
      RESP: begin
        if (flush || rsp_ready) state_next = IDLE;
      end
      DRAIN: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_pc    <= '0;
      rsp_inst0 <= '0;
      rsp_inst1 <= '0;
      rsp_adel  <= 1'b0;
      rsp_fault <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_pc    <= req_pc;
            rsp_adel  <= pc_adel;
            rsp_fault <= !pc_adel && pc_fault;
            if (pc_adel || pc_fault) begin
              rsp_inst0 <= NOP_WORD;
              rsp_inst1 <= NOP_WORD;
            end else if (buf_hit) begin
              rsp_inst0 <= buf_inst0;
              rsp_inst1 <= buf_inst1;
            end else begin
              mem_addr  <= req_pc;
            end
          end
        end
        RD0: begin
          if (mem_ack && !flush) begin
            rsp_inst0 <= mem_rdata;
            if (slot1_out) rsp_inst1 <= NOP_WORD;
            else           mem_addr  <= pc_plus4;
          end
        end
        RD1: begin
          if (mem_ack && !flush) rsp_inst1 <= mem_rdata;
        end
        RESP: begin
          if (flush || rsp_ready) begin
            rsp_adel  <= 1'b0;
            rsp_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
